// File: rtl/wmem_q14.sv
// Q14 synaptic weight memory: bulk fill engine, clamped STDP write port and a
// one-cycle-latency read port for the neuron core.
module wmem_q14 #(
  parameter  int F     = 48,
  parameter  int N     = 96,
  localparam int DEPTH = F * N,
  localparam int AW    = $clog2(F * N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_start,
  input  logic signed [15:0]   init_value,
  input  logic                 w_we,
  input  logic [AW-1:0]        w_addr,
  input  logic signed [15:0]   w_wdata,
  input  logic signed [15:0]   wmin,
  input  logic signed [15:0]   wmax,
  input  logic                 rd_req,
  input  logic [AW-1:0]        rd_addr,
  output logic                 rd_valid,
  output logic signed [15:0]   rd_data,
  output logic                 init_busy,
  output logic                 init_done,
  output logic [15:0]          wr_count,
  output logic                 addr_err
);

  typedef enum logic {IDLE, INIT} state_t;

  // Compare against the last valid address so a power-of-two DEPTH cannot wrap.
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t                state, state_next;
  logic [AW-1:0]         cnt;
  logic signed [15:0]    fill_val;
  logic signed [15:0]    mem [DEPTH];

  logic                  accept_init, fill_last, w_ok, rd_ok, stdp_write, rd_take;
  logic signed [15:0]    w_lo, w_clamped;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic signed [15:0]    mem_wdata;

  always_comb begin
    state_next = state;
    init_busy  = 1'b0;
    case (state)
      IDLE: if (init_start) state_next = INIT;
      INIT: begin
        init_busy = 1'b1;
        if (cnt == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept_init = (state == IDLE) && init_start;
  assign fill_last   = (state == INIT) && (cnt == LAST);
  assign w_ok        = (w_addr <= LAST);
  assign rd_ok       = (rd_addr <= LAST);
  assign stdp_write  = (state == IDLE) && w_we && w_ok;
  assign rd_take     = (state == IDLE) && rd_req;

  // With wmin > wmax the second stage always selects wmax.
  assign w_lo      = (w_wdata < wmin) ? wmin : w_wdata;
  assign w_clamped = (w_lo > wmax) ? wmax : w_lo;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = w_addr;
    mem_wdata = w_clamped;
    if (state == INIT) begin
      mem_we    = rst_n;
      mem_addr  = cnt;
      mem_wdata = fill_val;
    end else if (stdp_write) begin
      mem_we    = rst_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      fill_val <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= fill_last;
      if (accept_init) begin
        cnt      <= '0;
        fill_val <= init_value;
      end else if (state == INIT) begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
      addr_err <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (accept_init) begin
        wr_count <= '0;
        addr_err <= 1'b0;
      end else begin
        if (stdp_write && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        if ((state == IDLE) && ((w_we && !w_ok) || (rd_req && !rd_ok))) addr_err <= 1'b1;
      end
      rd_valid <= rd_take;
      // Write-first on a same-address collision.
      if (rd_take) begin
        if (!rd_ok)                              rd_data <= '0;
        else if (stdp_write && w_addr == rd_addr) rd_data <= w_clamped;
        else                                     rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_wmem_q14.sv
// Directed self-checking bench for wmem_q14 with a read-data scoreboard.
module tb_wmem_q14;
  localparam int F     = 48;
  localparam int N     = 96;
  localparam int DEPTH = F * N;
  localparam int AW    = $clog2(DEPTH);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                init_start = 1'b0;
  logic signed [15:0]  init_value = '0;
  logic                w_we = 1'b0;
  logic [AW-1:0]       w_addr = '0;
  logic signed [15:0]  w_wdata = '0;
  logic signed [15:0]  wmin = '0;
  logic signed [15:0]  wmax = '0;
  logic                rd_req = 1'b0;
  logic [AW-1:0]       rd_addr = '0;
  logic                rd_valid;
  logic signed [15:0]  rd_data;
  logic                init_busy;
  logic                init_done;
  logic [15:0]         wr_count;
  logic                addr_err;

  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  wmem_q14 #(.F(F), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_value(init_value),
    .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata), .wmin(wmin), .wmax(wmax),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .init_busy(init_busy), .init_done(init_done), .wr_count(wr_count), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read results land one cycle after the request; pop and compare them here.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_valid_unexpected", {31'b0, rd_valid}, 32'd0);
      end else begin
        string       t;
        logic [15:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check(t, {16'b0, rd_data}, {16'b0, e});
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = a; w_wdata = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [15:0] e, input string t);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = a;
    exp_q.push_back(e); tag_q.push_back(t);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic do_collide(input logic [AW-1:0] a, input logic [15:0] d, input logic [15:0] e);
    @(negedge clk);
    w_we = 1'b1; w_addr = a; w_wdata = d;
    rd_req = 1'b1; rd_addr = a;
    exp_q.push_back(e); tag_q.push_back("collide_rd");
    @(negedge clk);
    w_we = 1'b0; rd_req = 1'b0;
  endtask

  // Starts a fill and watches it; can poke the busy block or abort it with reset.
  task automatic run_fill(input logic [15:0] val, input int poke_at, input int abort_at, input string tag);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_idx = -1;
    @(negedge clk);
    init_start = 1'b1; init_value = val;
    @(negedge clk);
    init_start = 1'b0; init_value = 16'h0BAD;
    for (int i = 0; i < 4700; i++) begin
      if (i == 0) begin
        check({tag, "_addr_err_clr"}, {31'b0, addr_err}, 32'd0);
        check({tag, "_wr_count_clr"}, {16'b0, wr_count}, 32'd0);
      end
      if (init_busy) busy_cnt++;
      if (init_done) begin done_cnt++; done_idx = i; end
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",     {31'b0, init_busy}, 32'd0);
        check("abort_done",     {31'b0, init_done}, 32'd0);
        check("abort_rd_valid", {31'b0, rd_valid},  32'd0);
        check("abort_rd_data",  {16'b0, rd_data},   32'd0);
        check("abort_wr_count", {16'b0, wr_count},  32'd0);
        check("abort_addr_err", {31'b0, addr_err},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("abort_no_done", {31'b0, init_done}, 32'd0);
          check("abort_idle",    {31'b0, init_busy}, 32'd0);
        end
        return;
      end
      if (poke_at >= 0) begin
        if (i == poke_at) begin
          w_we = 1'b1; w_addr = 10; w_wdata = 16'h7777;
          rd_req = 1'b1; rd_addr = 10;
        end
        if (i == poke_at + 1) begin w_we = 1'b0; rd_req = 1'b0; end
        if (i == poke_at + 2) check({tag, "_busy_wr_count"}, {16'b0, wr_count}, 32'd0);
        if (i == poke_at + 10) begin init_start = 1'b1; init_value = 16'h4444; end
        if (i == poke_at + 11) init_start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, busy_cnt, DEPTH);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_cycle"},  done_idx, DEPTH);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_rd_valid",  {31'b0, rd_valid},  32'd0);
    check("rst_rd_data",   {16'b0, rd_data},   32'd0);
    check("rst_init_busy", {31'b0, init_busy}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_wr_count",  {16'b0, wr_count},  32'd0);
    check("rst_addr_err",  {31'b0, addr_err},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_fill(16'h2000, -1, -1, "fill1");
    do_read(0,    16'h2000, "fill1_rd0");
    do_read(2303, 16'h2000, "fill1_rd2303");
    do_read(4607, 16'h2000, "fill1_rd4607");

    wmin = 16'h0000; wmax = 16'h4000;
    do_write(5, 16'h7FFF);
    do_write(6, 16'hF000);
    do_write(7, 16'h1234);
    check("clamp_wr_count", {16'b0, wr_count}, 32'd3);
    do_read(5, 16'h4000, "clamp_hi");
    do_read(6, 16'h0000, "clamp_lo");
    do_read(7, 16'h1234, "clamp_pass");
    wmin = 16'h1000; wmax = 16'h0800;
    do_write(8, 16'h0100);
    wmin = 16'hF000; wmax = 16'h1000;
    do_write(9, 16'h8000);
    check("clamp_wr_count5", {16'b0, wr_count}, 32'd5);
    do_read(8, 16'h0800, "clamp_inverted");
    do_read(9, 16'hF000, "clamp_signed_neg");

    wmin = 16'h0000; wmax = 16'h4000;
    do_collide(100, 16'h0ABC, 16'h0ABC);
    @(negedge clk);
    check("hold_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("hold_rd_data",  {16'b0, rd_data},  32'h0ABC);
    do_read(100, 16'h0ABC, "collide_after");
    check("collide_wr_count", {16'b0, wr_count}, 32'd6);

    check("oor_addr_err_pre", {31'b0, addr_err}, 32'd0);
    do_write(13'd4608, 16'h1111);
    check("oor_wr_addr_err", {31'b0, addr_err}, 32'd1);
    check("oor_wr_count",    {16'b0, wr_count}, 32'd6);
    do_read(13'd5000, 16'h0000, "oor_rd_data");
    check("oor_rd_addr_err", {31'b0, addr_err}, 32'd1);

    run_fill(16'h3000, 50, -1, "fill2");
    do_read(10,   16'h3000, "busy_drop_rd10");
    do_read(4607, 16'h3000, "fill2_rd4607");
    check("fill2_wr_count", {16'b0, wr_count}, 32'd0);

    run_fill(16'h5555, -1, 1000, "abort");
    do_read(0,    16'h5555, "abort_written");
    do_read(4607, 16'h3000, "abort_unwritten");

    run_fill(16'h1111, -1, -1, "fill3");
    do_read(0,    16'h1111, "fill3_rd0");
    do_read(4607, 16'h1111, "fill3_rd4607");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
